// File: rtl/nand_page_program.sv
// NAND page-program controller: 80h, five address cycles, one page of data, 10h, busy wait, 70h status read.
// Optional busy watchdog in WAIT_RDY is enabled by defining NAND_PROG_TIMEOUT_EN.
`timescale 1ns/1ps
module nand_page_program #(
   parameter int tWP        = 2,
   parameter int tWH        = 1,
   parameter int tHOLD      = 1,
   parameter int tREA       = 2,
   parameter int tWB        = 16,
   parameter int PAGE_WORDS = 512
`ifdef NAND_PROG_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        CMD_IS_NEW,
   input  logic [27:0] NAND_ADDR,
   input  logic [31:0] DATA_IN,
   output logic        DATA_REQ,
   output logic        Operate_IS_OVER,
   output logic        PROG_FAIL,
   output logic        IO_DIR,
   output logic        CEn,
   output logic        WEn,
   output logic        REn,
   output logic        CLE,
   output logic        ALE,
   output logic        WPn,
   input  logic        RDY_BSYn,
   inout  wire  [7:0]  IO,
   output logic [3:0]  state_dbg,
   output logic [7:0]  status_dbg
);
   localparam int CMD_LAST  = tWP + tHOLD;
   localparam int BYTE_LAST = tWP + tWH - 1;
   localparam int READ_LAST = tREA + 1;
   localparam int MAX_A     = (CMD_LAST > BYTE_LAST) ? CMD_LAST : BYTE_LAST;
   localparam int MAX_B     = (READ_LAST > tWB) ? READ_LAST : tWB;
   localparam int BASE_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
`ifdef NAND_PROG_TIMEOUT_EN
   localparam int CNT_MAX   = (BASE_MAX > TIMEOUT_CYCLES) ? BASE_MAX : TIMEOUT_CYCLES;
`else
   localparam int CNT_MAX   = BASE_MAX;
`endif
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam int WW = (PAGE_WORDS > 1) ? $clog2(PAGE_WORDS) : 1;
   localparam logic [WW-1:0] LAST_WORD = WW'(PAGE_WORDS - 1);

   typedef enum logic [3:0] {
      IDLE, CMD1, ADDR, DATA, CMD2, WAIT_BSY, WAIT_RDY, CMD3, READ_ST, OVER
   } state_t;

   state_t          state_q, state_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic [2:0]      idx_q, idx_n;
   logic [WW-1:0]   word_cnt_q, word_cnt_n;
   logic [31:0]     word_q, word_n;
   logic [27:0]     addr_q, addr_n;
   logic [7:0]      status_q, status_n;
   logic [7:0]      io_q, io_n;
   logic            fail_n, rdy_meta, rdy_s;
   logic            cen_n, wen_n, ren_n, cle_n, ale_n, wpn_n, dir_n, req_n, over_n;

   assign IO         = IO_DIR ? io_q : 8'hzz;
   assign state_dbg  = state_q;
   assign status_dbg = status_q;

   // idx counts byte cycles inside ADDR/DATA; in DATA, idx==4 is the slot where the first word is fetched
   always_comb begin
      state_n    = state_q;
      cnt_n      = cnt_q + CW'(1);
      idx_n      = idx_q;
      word_cnt_n = word_cnt_q;
      word_n     = word_q;
      addr_n     = addr_q;
      fail_n     = PROG_FAIL;
      status_n   = status_q;
      case (state_q)
         IDLE: begin
            cnt_n = '0;
            if (CMD_IS_NEW) begin
               addr_n  = NAND_ADDR;
               fail_n  = 1'b0;
               state_n = CMD1;
            end
         end
         CMD1: if (cnt_q == CW'(CMD_LAST)) begin
            state_n = ADDR;
            cnt_n   = '0;
            idx_n   = '0;
         end
         ADDR: if (cnt_q == CW'(BYTE_LAST)) begin
            cnt_n = '0;
            if (idx_q == 3'd4) begin
               state_n    = DATA;
               word_cnt_n = '0;
            end else begin
               idx_n = idx_q + 3'd1;
            end
         end
         DATA: begin
            if (idx_q == 3'd4) begin
               word_n = DATA_IN;
               idx_n  = '0;
               cnt_n  = '0;
            end else if (cnt_q == CW'(BYTE_LAST)) begin
               cnt_n = '0;
               if (idx_q != 3'd3) begin
                  idx_n = idx_q + 3'd1;
               end else if (word_cnt_q == LAST_WORD) begin
                  state_n = CMD2;
               end else begin
                  word_cnt_n = word_cnt_q + WW'(1);
                  word_n     = DATA_IN;
                  idx_n      = '0;
               end
            end
         end
         CMD2: if (cnt_q == CW'(CMD_LAST)) begin
            state_n = WAIT_BSY;
            cnt_n   = '0;
         end
         WAIT_BSY: if (!rdy_s || cnt_q == CW'(tWB - 1)) begin
            state_n = WAIT_RDY;
            cnt_n   = '0;
         end
         WAIT_RDY: begin
            if (rdy_s) begin
               state_n = CMD3;
               cnt_n   = '0;
            end
`ifdef NAND_PROG_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_n = OVER;
               fail_n  = 1'b1;
            end
`endif
         end
         CMD3: if (cnt_q == CW'(CMD_LAST)) begin
            state_n = READ_ST;
            cnt_n   = '0;
         end
         READ_ST: begin
            if (cnt_q == CW'(tREA)) begin
               fail_n   = IO[0];
               status_n = IO;
            end
            if (cnt_q == CW'(READ_LAST)) state_n = OVER;
         end
         OVER:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Pins are decoded from the next state so every strobe comes straight off a flop
      cen_n  = 1'b0;
      wen_n  = 1'b1;
      ren_n  = 1'b1;
      cle_n  = 1'b0;
      ale_n  = 1'b0;
      wpn_n  = 1'b1;
      dir_n  = 1'b1;
      io_n   = io_q;
      req_n  = 1'b0;
      over_n = 1'b0;
      case (state_n)
         IDLE: begin
            cen_n = 1'b1;
            wpn_n = 1'b0;
            dir_n = 1'b0;
         end
         CMD1, CMD2, CMD3: begin
            cle_n = 1'b1;
            wen_n = !(cnt_n >= CW'(1) && cnt_n <= CW'(tWP));
            io_n  = (state_n == CMD1) ? 8'h80 : ((state_n == CMD2) ? 8'h10 : 8'h70);
         end
         ADDR: begin
            ale_n = 1'b1;
            wen_n = (cnt_n >= CW'(tWP));
            case (idx_n)
               3'd0:    io_n = addr_n[7:0];
               3'd1:    io_n = {4'h0, addr_n[11:8]};
               3'd2:    io_n = addr_n[19:12];
               3'd3:    io_n = addr_n[27:20];
               default: io_n = 8'h00;
            endcase
         end
         DATA: begin
            if (idx_n == 3'd4) begin
               req_n = 1'b1;
            end else begin
               wen_n = (cnt_n >= CW'(tWP));
               case (idx_n[1:0])
                  2'd0:    io_n = word_n[7:0];
                  2'd1:    io_n = word_n[15:8];
                  2'd2:    io_n = word_n[23:16];
                  default: io_n = word_n[31:24];
               endcase
               req_n = (idx_n == 3'd3) && (cnt_n == CW'(BYTE_LAST)) && (word_cnt_n != LAST_WORD);
            end
         end
         READ_ST: begin
            dir_n = 1'b0;
            ren_n = (cnt_n > CW'(tREA));
         end
         OVER: begin
            cen_n  = 1'b1;
            wpn_n  = 1'b0;
            dir_n  = 1'b0;
            over_n = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         idx_q           <= '0;
         word_cnt_q      <= '0;
         word_q          <= '0;
         addr_q          <= '0;
         status_q        <= '0;
         io_q            <= 8'h00;
         rdy_meta        <= 1'b1;
         rdy_s           <= 1'b1;
         PROG_FAIL       <= 1'b0;
         CEn             <= 1'b1;
         WEn             <= 1'b1;
         REn             <= 1'b1;
         CLE             <= 1'b0;
         ALE             <= 1'b0;
         WPn             <= 1'b0;
         IO_DIR          <= 1'b0;
         DATA_REQ        <= 1'b0;
         Operate_IS_OVER <= 1'b0;
      end else begin
         state_q         <= state_n;
         cnt_q           <= cnt_n;
         idx_q           <= idx_n;
         word_cnt_q      <= word_cnt_n;
         word_q          <= word_n;
         addr_q          <= addr_n;
         status_q        <= status_n;
         io_q            <= io_n;
         rdy_meta        <= RDY_BSYn;
         rdy_s           <= rdy_meta;
         PROG_FAIL       <= fail_n;
         CEn             <= cen_n;
         WEn             <= wen_n;
         REn             <= ren_n;
         CLE             <= cle_n;
         ALE             <= ale_n;
         WPn             <= wpn_n;
         IO_DIR          <= dir_n;
         DATA_REQ        <= req_n;
         Operate_IS_OVER <= over_n;
      end
   end
endmodule

// File: tb/tb_nand_page_program.sv
// Bench for nand_page_program: a small NAND model latches bus bytes on WEn rise and a scoreboard checks them.
`timescale 1ns/1ps
module tb_nand_page_program;
   localparam int PW = 4;
   localparam logic [3:0] S_IDLE = 4'd0, S_DATA = 4'd3;

   logic        CLK = 1'b0, RSTn = 1'b0, CMD_IS_NEW = 1'b0, RDY_BSYn = 1'b1;
   logic [27:0] NAND_ADDR = '0;
   logic [31:0] DATA_IN = '0;
   logic [7:0]  status_val = 8'h00;
   wire         DATA_REQ, Operate_IS_OVER, PROG_FAIL, IO_DIR, CEn, WEn, REn, CLE, ALE, WPn;
   wire  [7:0]  IO;
   wire  [3:0]  state_dbg;
   wire  [7:0]  status_dbg;
   wire         nand_drive;

   assign nand_drive = !REn && !CEn && !IO_DIR;
   assign IO = nand_drive ? status_val : 8'hzz;

   nand_page_program #(.PAGE_WORDS(PW)
`ifdef NAND_PROG_TIMEOUT_EN
      , .TIMEOUT_CYCLES(100)
`endif
   ) dut (
      .CLK(CLK), .RSTn(RSTn), .CMD_IS_NEW(CMD_IS_NEW), .NAND_ADDR(NAND_ADDR), .DATA_IN(DATA_IN),
      .DATA_REQ(DATA_REQ), .Operate_IS_OVER(Operate_IS_OVER), .PROG_FAIL(PROG_FAIL), .IO_DIR(IO_DIR),
      .CEn(CEn), .WEn(WEn), .REn(REn), .CLE(CLE), .ALE(ALE), .WPn(WPn), .RDY_BSYn(RDY_BSYn),
      .IO(IO), .state_dbg(state_dbg), .status_dbg(status_dbg)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   int checks = 0, failures = 0;
   logic [9:0] exp_q[$];
   logic       fail_exp_q[$];
   bit  mon_en = 1'b1, confirm_pulse = 1'b0, prev_wen = 1'b1, prev_ren = 1'b1;
   int  wen_low = 0, ren_low = 0, ale_rises = 0, over_cnt = 0, over_len = 0;
   int  bsy_cycles = 0, rdy_cycles = 0, req_cnt = 0, word_idx = 0, busy_mode = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_cen"}, CEn, 1);
      chk({tag, "_wen"}, WEn, 1);
      chk({tag, "_ren"}, REn, 1);
      chk({tag, "_cle"}, CLE, 0);
      chk({tag, "_ale"}, ALE, 0);
      chk({tag, "_wpn"}, WPn, 0);
      chk({tag, "_io_dir"}, IO_DIR, 0);
      chk({tag, "_data_req"}, DATA_REQ, 0);
      chk({tag, "_over"}, Operate_IS_OVER, 0);
      chk({tag, "_prog_fail"}, PROG_FAIL, 0);
      chk({tag, "_state"}, state_dbg, S_IDLE);
   endtask

   // monitor: bus bytes, strobe widths, completion pulses, wait-state lengths
   initial forever begin
      @(negedge CLK);
      if (!WEn) wen_low++;
      else begin
         if (!prev_wen) begin
            if (ALE) ale_rises++;
            if (CLE && IO === 8'h10) confirm_pulse = 1'b1;
            if (mon_en) begin
               chk("we_low_width", wen_low, 2);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_byte: got cle=%0b ale=%0b io=%0h expected none", CLE, ALE, IO);
               end else begin
                  chk("bus_byte", {22'b0, CLE, ALE, IO}, {22'b0, exp_q.pop_front()});
               end
            end
         end
         wen_low = 0;
      end
      prev_wen = WEn;
      if (!REn) ren_low++;
      else begin
         if (!prev_ren && mon_en) chk("re_low_width", ren_low, 3);
         ren_low = 0;
      end
      prev_ren = REn;
      if (Operate_IS_OVER) begin
         if (over_len == 0) begin
            over_cnt++;
            if (mon_en) begin
               if (fail_exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_over: got pulse expected none");
               end else begin
                  chk("prog_fail_at_over", PROG_FAIL, fail_exp_q.pop_front());
               end
            end
         end
         over_len++;
      end else if (over_len != 0) begin
         chk("over_width", over_len, 1);
         over_len = 0;
      end
      if (state_dbg == 4'd5) bsy_cycles++;
      if (state_dbg == 4'd6) rdy_cycles++;
   end

   // bridge driver: word k carries bytes 4k..4k+3, LSB first; junk whenever no request is open
   initial forever begin
      @(negedge CLK);
      if (DATA_REQ) begin
         logic [7:0] b;
         b = 8'(4 * word_idx);
         DATA_IN = {b + 8'd3, b + 8'd2, b + 8'd1, b};
         word_idx++;
         req_cnt++;
      end else begin
         DATA_IN = $urandom;
      end
   end

   // NAND busy model: 0 = busy 50 cycles, 1 = never busy, 2 = busy forever
   initial forever begin
      @(negedge CLK);
      if (confirm_pulse) begin
         confirm_pulse = 1'b0;
         if (busy_mode == 0) begin
            repeat (2) @(negedge CLK);
            RDY_BSYn = 1'b0;
            repeat (50) @(negedge CLK);
            RDY_BSYn = 1'b1;
         end else if (busy_mode == 2) begin
            repeat (2) @(negedge CLK);
            RDY_BSYn = 1'b0;
         end
      end
   end

   // abytes: the five address bytes in bus order, hand-derived from addr
   task automatic run_op(input logic [27:0] addr, input logic [39:0] abytes, input logic [7:0] st,
                         input int mode, input bit inject, input logic exp_fail);
      int n, over0;
      bit injected;
      injected = 1'b0;
      exp_q.push_back({2'b10, 8'h80});
      for (int i = 0; i < 5; i++) exp_q.push_back({2'b01, abytes[39-8*i -: 8]});
      for (int i = 0; i < 4 * PW; i++) exp_q.push_back({2'b00, 8'(i)});
      exp_q.push_back({2'b10, 8'h10});
      if (mode != 2) exp_q.push_back({2'b10, 8'h70});
      fail_exp_q.push_back(exp_fail);
      status_val = st;
      busy_mode  = mode;
      word_idx   = 0;
      req_cnt    = 0;
      bsy_cycles = 0;
      rdy_cycles = 0;
      over0      = over_cnt;
      NAND_ADDR  = addr;
      CMD_IS_NEW = 1'b1;
      @(negedge CLK);
      CMD_IS_NEW = 1'b0;
      NAND_ADDR  = 28'($urandom);
      chk("fail_cleared_on_start", PROG_FAIL, 0);
      chk("cen_after_start", CEn, 0);
      chk("wpn_after_start", WPn, 1);
      n = 0;
      while (over_cnt == over0 && n < 3000) begin
         @(negedge CLK);
         n++;
         if (inject && !injected && state_dbg == S_DATA && word_idx == 2) begin
            CMD_IS_NEW = 1'b1;
            injected   = 1'b1;
         end else begin
            CMD_IS_NEW = 1'b0;
         end
      end
      CMD_IS_NEW = 1'b0;
      chk("op_done_in_budget", n < 3000, 1);
      repeat (2) @(negedge CLK);
      chk("bytes_left", exp_q.size(), 0);
      chk("data_req_count", req_cnt, PW);
      chk("over_count", over_cnt - over0, 1);
      chk("idle_after_op", state_dbg, S_IDLE);
      exp_q.delete();
      fail_exp_q.delete();
   endtask

   initial begin
      int n, over0;
      repeat (3) @(negedge CLK);
      chk_reset("reset");
      RSTn = 1'b1;
      repeat (2) @(negedge CLK);
      chk("idle_stays_idle", state_dbg, S_IDLE);

      // 0ABCDEF1: [7:0]=F1, {0,[11:8]}=0E, [19:12]=CD, [27:20]=AB, then 00
      run_op(28'hABCDEF1, 40'hF1_0E_CD_AB_00, 8'h00, 0, 1'b0, 1'b0);
      chk("bsy_exit_on_busy", bsy_cycles < 16, 1);
      chk("prog_fail_pass", PROG_FAIL, 0);

      run_op(28'hABCDEF1, 40'hF1_0E_CD_AB_00, 8'hE1, 0, 1'b0, 1'b1);
      repeat (20) @(negedge CLK);
      chk("prog_fail_held", PROG_FAIL, 1);
      chk("status_byte", status_dbg, 8'hE1);

      run_op(28'hABCDEF1, 40'hF1_0E_CD_AB_00, 8'h00, 1, 1'b0, 1'b0);
      chk("bsy_twb_cycles", bsy_cycles, 16);

      run_op(28'hABCDEF1, 40'hF1_0E_CD_AB_00, 8'h00, 0, 1'b1, 1'b0);
      over0 = over_cnt;
      repeat (30) @(negedge CLK);
      chk("no_restart_after_inject", over_cnt - over0, 0);
      chk("idle_after_inject", state_dbg, S_IDLE);

      // abort during the third address byte
      mon_en     = 1'b0;
      ale_rises  = 0;
      over0      = over_cnt;
      NAND_ADDR  = 28'hABCDEF1;
      CMD_IS_NEW = 1'b1;
      @(negedge CLK);
      CMD_IS_NEW = 1'b0;
      n = 0;
      while (ale_rises < 2 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk("reached_addr_byte3", n < 200, 1);
      chk("abort_in_addr", ALE, 1);
      #2 RSTn = 1'b0;
      #1 chk_reset("async_reset");
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
      repeat (3) @(negedge CLK);
      chk("no_over_on_abort", over_cnt - over0, 0);
      mon_en = 1'b1;

      // 1234567: 67, 05, 34, 12, 00
      run_op(28'h1234567, 40'h67_05_34_12_00, 8'h00, 0, 1'b0, 1'b0);

`ifdef NAND_PROG_TIMEOUT_EN
      run_op(28'h1234567, 40'h67_05_34_12_00, 8'h00, 2, 1'b0, 1'b1);
      chk("timeout_wait_cycles", rdy_cycles, 100);
      chk("timeout_prog_fail", PROG_FAIL, 1);
      RDY_BSYn = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
